// File: rtl/wb_commit_regs.sv
// Write-back commit stage: GPR file, HI/LO pair and LLbit.
// Reads are combinational and see this cycle's write through a bypass path.
module wb_commit_regs #(
    parameter int NREG = 32,
    parameter int DW   = 32,
    parameter int AW   = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] wb_wd,
    input  logic          wb_wreg,
    input  logic [DW-1:0] wb_wdata,
    input  logic [DW-1:0] wb_hi,
    input  logic [DW-1:0] wb_lo,
    input  logic          wb_whilo,
    input  logic          wb_LLbit_we,
    input  logic          wb_LLbit_value,
    input  logic          flush,
    input  logic          re1,
    input  logic [AW-1:0] raddr1,
    output logic [DW-1:0] rdata1,
    input  logic          re2,
    input  logic [AW-1:0] raddr2,
    output logic [DW-1:0] rdata2,
    output logic [DW-1:0] hi_o,
    output logic [DW-1:0] lo_o,
    output logic          LLbit_o
);

    logic [DW-1:0] gpr_reg [NREG];
    logic [DW-1:0] hi_reg;
    logic [DW-1:0] lo_reg;
    logic          llbit_reg;
    logic          gpr_we;

    // Addresses at or beyond NREG are dropped rather than wrapped.
    assign gpr_we = wb_wreg && (wb_wd != '0) && (32'(wb_wd) < NREG);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                gpr_reg[i] <= '0;
            end
        end else if (gpr_we) begin
            gpr_reg[wb_wd] <= wb_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hi_reg <= '0;
            lo_reg <= '0;
        end else if (wb_whilo) begin
            hi_reg <= wb_hi;
            lo_reg <= wb_lo;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            llbit_reg <= 1'b0;
        end else if (flush) begin
            llbit_reg <= 1'b0;
        end else if (wb_LLbit_we) begin
            llbit_reg <= wb_LLbit_value;
        end
    end

    logic [1:0]    rd_en;
    logic [AW-1:0] rd_addr [2];

    assign rd_en      = {re2, re1};
    assign rd_addr[0] = raddr1;
    assign rd_addr[1] = raddr2;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_rd
            logic [DW-1:0] data;
            always_comb begin
                data = '0;
                if (!rst || !rd_en[gi] || rd_addr[gi] == '0 || 32'(rd_addr[gi]) >= NREG) begin
                    data = '0;
                end else if (wb_wreg && wb_wd == rd_addr[gi]) begin
                    data = wb_wdata;
                end else begin
                    data = gpr_reg[rd_addr[gi]];
                end
            end
        end
    endgenerate

    assign rdata1 = g_rd[0].data;
    assign rdata2 = g_rd[1].data;

    assign hi_o    = !rst ? '0 : (wb_whilo ? wb_hi : hi_reg);
    assign lo_o    = !rst ? '0 : (wb_whilo ? wb_lo : lo_reg);
    assign LLbit_o = !rst ? 1'b0 : (flush ? 1'b0 : (wb_LLbit_we ? wb_LLbit_value : llbit_reg));

endmodule

// File: tb/tb_wb_commit_regs.sv
// Directed bench for wb_commit_regs: reset, GPR write/read/bypass, r0, HI/LO, LLbit.
module tb_wb_commit_regs;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  wb_wd;
    logic        wb_wreg;
    logic [31:0] wb_wdata;
    logic [31:0] wb_hi;
    logic [31:0] wb_lo;
    logic        wb_whilo;
    logic        wb_LLbit_we;
    logic        wb_LLbit_value;
    logic        flush;
    logic        re1;
    logic [4:0]  raddr1;
    logic [31:0] rdata1;
    logic        re2;
    logic [4:0]  raddr2;
    logic [31:0] rdata2;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic        LLbit_o;

    int vec_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    wb_commit_regs #(.NREG(32), .DW(32), .AW(5)) dut (
        .clk(clk), .rst(rst),
        .wb_wd(wb_wd), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata),
        .wb_hi(wb_hi), .wb_lo(wb_lo), .wb_whilo(wb_whilo),
        .wb_LLbit_we(wb_LLbit_we), .wb_LLbit_value(wb_LLbit_value),
        .flush(flush),
        .re1(re1), .raddr1(raddr1), .rdata1(rdata1),
        .re2(re2), .raddr2(raddr2), .rdata2(rdata2),
        .hi_o(hi_o), .lo_o(lo_o), .LLbit_o(LLbit_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, obs);
        end
    endtask

    // Advance past the next rising edge; inputs change and samples happen mid-cycle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wb_wreg = 0; wb_whilo = 0; wb_LLbit_we = 0; flush = 0;
    endtask

    initial begin
        rst = 0; wb_wd = 0; wb_wreg = 0; wb_wdata = 0; wb_hi = 0; wb_lo = 0;
        wb_whilo = 0; wb_LLbit_we = 0; wb_LLbit_value = 0; flush = 0;
        re1 = 1; raddr1 = 5; re2 = 1; raddr2 = 5;
        #2;
        chk("reset_rdata1", rdata1, 32'h0);
        chk("reset_hi", hi_o, 32'h0);
        chk("reset_lo", lo_o, 32'h0);
        chk("reset_llbit", {31'h0, LLbit_o}, 32'h0);
        step();

        // Release together with a write: that write commits at the release edge.
        rst = 1; wb_wreg = 1; wb_wd = 4; wb_wdata = 32'h44;
        step();
        idle(); raddr1 = 4; #1;
        chk("release_write", rdata1, 32'h44);

        // Basic write then read, including same-cycle bypass.
        wb_wreg = 1; wb_wd = 3; wb_wdata = 32'hDEADBEEF; raddr1 = 3; #1;
        chk("wr3_bypass", rdata1, 32'hDEADBEEF);
        step();
        idle(); #1;
        chk("rd3", rdata1, 32'hDEADBEEF);
        re1 = 0; #1;
        chk("rd3_re0", rdata1, 32'h0);
        re1 = 1;

        // Both ports on the address being overwritten.
        wb_wreg = 1; wb_wd = 7; wb_wdata = 32'h11;
        step();
        idle(); raddr1 = 7; raddr2 = 7; #1;
        chk("rd7_old_p1", rdata1, 32'h11);
        chk("rd7_old_p2", rdata2, 32'h11);
        wb_wreg = 1; wb_wd = 7; wb_wdata = 32'h55; #1;
        chk("byp7_p1", rdata1, 32'h55);
        chk("byp7_p2", rdata2, 32'h55);
        step();
        idle(); #1;
        chk("rd7_new_p1", rdata1, 32'h55);
        chk("rd7_new_p2", rdata2, 32'h55);
        raddr2 = 3; #1;
        chk("rd3_p2", rdata2, 32'hDEADBEEF);

        // Register 0 ignores writes and never bypasses.
        wb_wreg = 1; wb_wd = 0; wb_wdata = 32'hFFFFFFFF; raddr1 = 0; #1;
        chk("r0_same", rdata1, 32'h0);
        step();
        idle(); #1;
        chk("r0_next", rdata1, 32'h0);

        // HI/LO bypass and hold.
        wb_whilo = 1; wb_hi = 32'h1; wb_lo = 32'h2; #1;
        chk("hi_byp", hi_o, 32'h1);
        chk("lo_byp", lo_o, 32'h2);
        step();
        idle(); wb_hi = 32'h9; wb_lo = 32'h8; #1;
        chk("hi_hold", hi_o, 32'h1);
        chk("lo_hold", lo_o, 32'h2);
        step();
        chk("hi_hold2", hi_o, 32'h1);

        // LLbit set, hold, then flush beats a concurrent set.
        wb_LLbit_we = 1; wb_LLbit_value = 1; #1;
        chk("ll_byp", {31'h0, LLbit_o}, 32'h1);
        step();
        idle(); #1;
        chk("ll_hold", {31'h0, LLbit_o}, 32'h1);
        flush = 1; wb_LLbit_we = 1; wb_LLbit_value = 1; #1;
        chk("ll_flush_same", {31'h0, LLbit_o}, 32'h0);
        step();
        idle(); #1;
        chk("ll_flush_after", {31'h0, LLbit_o}, 32'h0);
        wb_LLbit_we = 1; wb_LLbit_value = 1;
        step();
        idle(); wb_LLbit_we = 1; wb_LLbit_value = 0; #1;
        chk("ll_clear_byp", {31'h0, LLbit_o}, 32'h0);
        step();
        idle(); #1;
        chk("ll_clear_after", {31'h0, LLbit_o}, 32'h0);

        // Flush does not block GPR or HI/LO commits in the same cycle.
        flush = 1; wb_wreg = 1; wb_wd = 9; wb_wdata = 32'hA5A5A5A5;
        wb_whilo = 1; wb_hi = 32'h3; wb_lo = 32'h4;
        wb_LLbit_we = 1; wb_LLbit_value = 1;
        step();
        idle(); raddr1 = 9; raddr2 = 9; #1;
        chk("sim_gpr9", rdata1, 32'hA5A5A5A5);
        chk("sim_gpr9_p2", rdata2, 32'hA5A5A5A5);
        chk("sim_hi", hi_o, 32'h3);
        chk("sim_lo", lo_o, 32'h4);
        chk("sim_ll", {31'h0, LLbit_o}, 32'h0);

        // Asynchronous reset mid-cycle wipes state immediately.
        wb_wreg = 1; wb_wd = 5; wb_wdata = 32'h12345678;
        wb_whilo = 1; wb_hi = 32'hA; wb_lo = 32'hB;
        step();
        idle(); raddr1 = 5; #1;
        chk("pre_rst_r5", rdata1, 32'h12345678);
        chk("pre_rst_hi", hi_o, 32'hA);
        rst = 0; #1;
        chk("async_rst_r5", rdata1, 32'h0);
        chk("async_rst_hi", hi_o, 32'h0);
        step();
        rst = 1; #1;
        chk("post_rst_r5", rdata1, 32'h0);
        chk("post_rst_hi", hi_o, 32'h0);
        step();
        raddr1 = 3; raddr2 = 9; #1;
        chk("post_rst_r3", rdata1, 32'h0);
        chk("post_rst_r9", rdata2, 32'h0);
        chk("post_rst_lo", lo_o, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
